vcve2_obi_mem_arbiter: RTL and testbench

// - Shares one OBI memory port between the core instruction and data interfaces (2:1 arbiter).
// - Sits between vcve2_core and a single-ported memory/bus in area-reduced vcve2 configurations.
// - Round-robin arbitration; the grant locks while a request waits for mem_gnt_i.
// - Routes in-order responses back to their requester via an ID FIFO.
//

---
 rtl/vcve2_obi_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vcve2_obi_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_obi_mem_arbiter.sv
// vcve2_obi_mem_arbiter
//
// Shares one OBI memory port between the core instruction and data
// interfaces. Arbitration is round-robin between the two requesters. Once a
// request has been presented to memory without a grant, the selection is
// locked until memory grants it, because OBI does not allow a request to be
// withdrawn. Memory answers in order, so a small FIFO of requester IDs (one
// entry per granted transaction) routes each response back to its owner.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   instr_req_i/instr_addr_i        instruction request
//   instr_gnt_o/instr_rvalid_o/instr_rdata_o/instr_err_o   instruction grant/response
//   data_req_i/we/be/addr/wdata     data request
//   data_gnt_o/data_rvalid_o/data_rdata_o/data_err_o       data grant/response
//   mem_req_o/we/be/addr/wdata      shared memory request
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i/mem_err_i           shared memory grant/response
//   outstanding_o                   number of granted-but-unanswered transactions
//   busy_o                          transactions in flight or a request held

module vcve2_obi_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            instr_req_i,
    input  logic [31:0]     instr_addr_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    output logic [31:0]     instr_rdata_o,
    output logic            instr_err_o,

    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    output logic [31:0]     data_rdata_o,
    output logic            data_err_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    input  logic            mem_err_i,

    output logic [CntW-1:0] outstanding_o,
    output logic            busy_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                    state_q;
    logic                      hold_id_q;   // 0 = instr, 1 = data
    logic                      last_q;      // id of the most recent grant
    logic [CntW-1:0]           count_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic                      id_fifo_q [MaxOutstanding];

    logic                      fifo_full;
    logic                      sel_arb;
    logic                      sel;
    logic                      push;
    logic                      pop;
    logic                      head_id;
    logic [MaxOutstanding-1:0] entry_we;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Full is judged on the registered count, so a pop in the same cycle
    // does not free a slot until the following cycle.
    assign fifo_full = (count_q >= CntW'(MaxOutstanding));

    // Tie goes to whoever was not granted last; a lone requester always wins.
    assign sel_arb = (instr_req_i & data_req_i) ? ~last_q : data_req_i;
    assign sel     = (state_q == HOLD) ? hold_id_q : sel_arb;

    // A held request is never retracted, even if the ID FIFO is full; this
    // cannot overflow because HOLD is only entered from a non-full ARB cycle.
    always_comb begin
        mem_req_o = 1'b0;
        if (!rst_i) begin
            if (state_q == HOLD) begin
                mem_req_o = 1'b1;
            end else begin
                mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
            end
        end
    end

    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & ~sel;
    assign data_gnt_o  = push & sel;

    assign mem_addr_o  = sel ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel & data_we_i;
    assign mem_be_o    = sel ? data_be_i    : 4'hF;
    assign mem_wdata_o = sel ? data_wdata_i : 32'h0;

    // Responses with nothing outstanding are dropped.
    assign pop     = ~rst_i & mem_rvalid_i & (count_q != '0);
    assign head_id = id_fifo_q[rd_ptr_q];

    assign instr_rvalid_o = pop & ~head_id;
    assign data_rvalid_o  = pop & head_id;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign outstanding_o = count_q;
    assign busy_o        = (count_q != '0) || (state_q == HOLD);

    // ID storage: one write enable per entry, selected by the write pointer.
    for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_entry_we
        assign entry_we[gi] = push && (wr_ptr_q == PtrW'(gi));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MaxOutstanding; i++) begin
            if (entry_we[i]) begin
                id_fifo_q[i] <= sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            hold_id_q <= 1'b0;
            last_q    <= 1'b1;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q   <= HOLD;
                        hold_id_q <= sel_arb;
                    end
                end
                HOLD: begin
                    if (mem_gnt_i) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase

            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
                last_q   <= sel;
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vcve2_obi_mem_arbiter.sv
// Bench for vcve2_obi_mem_arbiter. A reference model (queue of granted ids,
// a held-request flag and the last granted id) predicts grants and the
// request mux every cycle; expected responses go into a scoreboard queue that
// a separate negedge monitor pops whenever the DUT raises an rvalid.

module tb_vcve2_obi_mem_arbiter;

    localparam int MAXO = 2;
    localparam int CNTW = $clog2(MAXO + 1);
    localparam logic [31:0] IA  = 32'h0000_1000;
    localparam logic [31:0] DA  = 32'h0000_2000;
    localparam logic [31:0] DWD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i = 1'b1;
    logic            instr_req_i = 1'b0;
    logic [31:0]     instr_addr_i = '0;
    logic            instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]     instr_rdata_o;
    logic            data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]      data_be_i = '0;
    logic [31:0]     data_addr_i = '0, data_wdata_i = '0;
    logic            data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0]     data_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [31:0]     mem_addr_o, mem_wdata_o;
    logic            mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0]     mem_rdata_i = '0;
    logic [CNTW-1:0] outstanding_o;
    logic            busy_o;

    vcve2_obi_mem_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
    } resp_t;
    resp_t exp_q[$];

    // Reference model state
    bit m_hold = 1'b0, m_hold_id = 1'b0, m_last = 1'b1;
    bit m_ids[$];

    // Expectations for the current cycle
    bit e_req, e_sel, e_igt, e_dgt, e_busy;
    int e_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dwd,
                         input bit gnt, input bit rv, input logic [31:0] rd, input bit er);
        resp_t r;
        @(posedge clk); #1;
        rst_i = rst; instr_req_i = ir; instr_addr_i = ia;
        data_req_i = dr; data_we_i = dwe; data_be_i = dbe;
        data_addr_i = da; data_wdata_i = dwd;
        mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;

        e_cnt  = m_ids.size();
        e_busy = (e_cnt != 0) || m_hold;
        if (rst) begin
            e_req = 1'b0; e_sel = 1'b0;
        end else if (m_hold) begin
            e_req = 1'b1; e_sel = m_hold_id;
        end else begin
            e_req = (ir || dr) && (e_cnt < MAXO);
            e_sel = (ir && dr) ? !m_last : dr;
        end
        e_igt = e_req && gnt && !e_sel;
        e_dgt = e_req && gnt && e_sel;

        if (!rst && rv && m_ids.size() != 0) begin
            r.id = m_ids.pop_front(); r.rdata = rd; r.err = er;
            exp_q.push_back(r);
        end
        if (rst) begin
            m_hold = 1'b0; m_hold_id = 1'b0; m_last = 1'b1;
            m_ids.delete();
        end else begin
            if (e_igt || e_dgt) begin
                m_ids.push_back(e_sel);
                m_last = e_sel;
            end
            if (m_hold) begin
                if (gnt) m_hold = 1'b0;
            end else if (e_req && !gnt) begin
                m_hold = 1'b1; m_hold_id = e_sel;
            end
        end

        @(negedge clk);
        check("mem_req", mem_req_o, e_req);
        check("instr_gnt", instr_gnt_o, e_igt);
        check("data_gnt", data_gnt_o, e_dgt);
        check("outstanding", outstanding_o, e_cnt);
        check("busy", busy_o, e_busy);
        if (e_req) begin
            check("mem_addr", mem_addr_o, e_sel ? da : ia);
            check("mem_we", mem_we_o, e_sel ? dwe : 1'b0);
            check("mem_be", mem_be_o, e_sel ? dbe : 4'hF);
            check("mem_wdata", mem_wdata_o, e_sel ? dwd : 32'h0);
        end
    endtask

    task automatic dcyc(input bit rst, input bit ir, input bit dr, input bit gnt,
                        input bit rv, input bit er);
        cycle(rst, ir, IA, dr, 1'b1, 4'h3, DA, DWD, gnt, rv, $urandom(), er);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        resp_t r;
        if (instr_rvalid_o && data_rvalid_o) begin
            checks++; failures++;
            $display("FAIL rvalid_both: got instr=1 data=1 expected one-hot at %0t", $time);
        end
        if (instr_rvalid_o || data_rvalid_o) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rvalid_unexpected: got instr=%0b data=%0b expected none at %0t",
                         instr_rvalid_o, data_rvalid_o, $time);
            end else begin
                r = exp_q.pop_front();
                check("rvalid_route", data_rvalid_o, r.id);
                check("rdata", r.id ? data_rdata_o : instr_rdata_o, r.rdata);
                check("err", r.id ? data_err_o : instr_err_o, r.err);
                $display("resp %s rdata=%h err=%0b", r.id ? "D" : "I", r.rdata, r.err);
            end
        end else if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            checks++; failures++;
            $display("FAIL rvalid_missing: got none expected id=%0b at %0t", r.id, $time);
        end
    end

    // Random requester/memory state
    bit          cur_ir = 0, cur_dr = 0, cur_dwe = 0;
    logic [31:0] cur_ia = '0, cur_da = '0, cur_dwd = '0;
    logic [3:0]  cur_dbe = '0;
    bit          prev_igt = 0, prev_dgt = 0;

    task automatic rand_cycle(input int p_req, input int p_gnt, input int p_rv);
        bit gnt, rv;
        if (!cur_ir || prev_igt) begin
            cur_ir = ($urandom_range(0, 99) < p_req);
            cur_ia = $urandom() & 32'hFFFF_FFFC;
        end
        if (!cur_dr || prev_dgt) begin
            cur_dr  = ($urandom_range(0, 99) < p_req);
            cur_da  = $urandom() & 32'hFFFF_FFFC;
            cur_dwe = $urandom_range(0, 1);
            cur_dbe = 4'($urandom_range(0, 15));
            cur_dwd = $urandom();
        end
        gnt = ($urandom_range(0, 99) < p_gnt);
        rv  = (m_ids.size() != 0) ? ($urandom_range(0, 99) < p_rv)
                                  : ($urandom_range(0, 99) < 5);
        cycle(1'b0, cur_ir, cur_ia, cur_dr, cur_dwe, cur_dbe, cur_da, cur_dwd,
              gnt, rv, $urandom(), $urandom_range(0, 1));
        prev_igt = e_igt;
        prev_dgt = e_dgt;
    endtask

    initial begin
        // Reset
        dcyc(1, 0, 0, 0, 0, 0);
        dcyc(1, 1, 1, 1, 0, 0);
        check("reset_grants_off", {instr_gnt_o, data_gnt_o, mem_req_o}, 3'b000);

        // Tie after reset: instr first, then strict alternation
        dcyc(0, 1, 1, 1, 0, 0);
        check("first_tie_instr", instr_gnt_o, 1'b1);
        for (int k = 0; k < 6; k++) begin
            dcyc(0, 1, 1, 1, 1, 0);
            check("alternate_data", data_gnt_o, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        dcyc(0, 0, 0, 0, 1, 0);

        // Data waits three cycles without grant, instr arrives: hold data
        dcyc(0, 0, 1, 0, 0, 0);
        dcyc(0, 0, 1, 0, 0, 0);
        dcyc(0, 0, 1, 0, 0, 0);
        dcyc(0, 1, 1, 0, 0, 0);
        check("hold_addr", mem_addr_o, DA);
        dcyc(0, 1, 1, 1, 0, 0);
        check("hold_data_gnt", data_gnt_o, 1'b1);
        dcyc(0, 1, 0, 1, 0, 0);

        // Full: no request until one cycle after a response
        dcyc(0, 1, 1, 1, 0, 0);
        check("full_no_req", mem_req_o, 1'b0);
        check("full_count", outstanding_o, 2);
        dcyc(0, 1, 1, 1, 1, 0);
        check("full_pop_still_blocked", mem_req_o, 1'b0);
        dcyc(0, 1, 1, 1, 0, 0);
        check("req_resumes", mem_req_o, 1'b1);
        dcyc(0, 0, 0, 0, 1, 0);
        dcyc(0, 0, 0, 0, 1, 0);
        dcyc(0, 0, 0, 0, 1, 0);  // spurious at zero outstanding
        check("spurious_ignored", {instr_rvalid_o, data_rvalid_o}, 2'b00);

        // I, D, I with responses one cycle later; error on the D beat
        dcyc(0, 1, 0, 1, 0, 0);
        dcyc(0, 0, 1, 1, 1, 0);
        check("push_pop_count", outstanding_o, 1);
        dcyc(0, 1, 0, 1, 1, 1);
        check("data_err_beat", data_err_o, 1'b1);
        dcyc(0, 0, 0, 0, 1, 0);
        dcyc(0, 0, 0, 0, 1, 0);

        // Reset while holding with a transaction outstanding
        dcyc(0, 1, 0, 1, 0, 0);
        dcyc(0, 0, 1, 0, 0, 0);
        dcyc(1, 0, 1, 0, 1, 0);
        dcyc(0, 0, 0, 0, 0, 0);
        check("post_reset_count", outstanding_o, 0);
        check("post_reset_busy", busy_o, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_cycle((n < 1500) ? 70 : 30, (n % 1000 < 500) ? 80 : 40, 50);
        end
        for (int n = 0; n < 6; n++) begin
            dcyc(0, 0, 0, 0, 1, 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
